// File: rtl/kl10_pkg.sv
// Shared KL10 memory-bus types: sequencer states, address/word types and parity helpers.
package kl10_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_ACCESS,
        ST_RDXFER,
        ST_WRXFER
    } mseq_state_e;

    typedef logic [21:0] adr_t;
    typedef logic [35:0] word_t;

    // Bit that makes the total number of ones (data plus this bit) odd.
    function automatic logic odd_par(input word_t w);
        return ~^w;
    endfunction

    // First pending slot met when walking first, first+1, ... mod 4.
    function automatic logic [1:0] next_slot(input logic [3:0] pending, input logic [1:0] first);
        logic [1:0] slot;
        logic [1:0] s;
        slot = first;
        for (int k = 3; k >= 0; k--) begin
            s = first + 2'(k);
            if (pending[s]) begin
                slot = s;
            end
        end
        return slot;
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM, one-cycle registered read (read-before-write).
module mem_ram
    import kl10_pkg::*;
#(
    parameter int DEPTH = 262144,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mbus_mem_seq.sv
// MBUS memory sequencer: accepts one quadword request from port A or B, acknowledges it,
// then streams requested words out of (or into) the local RAM in wrap-around order.
module mbus_mem_seq
    import kl10_pkg::*;
#(
    parameter int MEMSIZE    = 262144,
    parameter int ACK_DLY    = 2,
    parameter int ACCESS_DLY = 4
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       start_a,
    input  logic       start_b,
    input  logic       rd_rq,
    input  logic       wr_rq,
    input  logic [3:0] rq,
    input  adr_t       adr,
    input  logic       adr_par,
    input  logic       mem_reset,
    input  word_t      d_out,
    input  logic       out_valid_a,
    input  logic       out_valid_b,
    output logic       ackn_a,
    output logic       ackn_b,
    output word_t      d_in,
    output logic       par_in,
    output logic       in_valid_a,
    output logic       in_valid_b,
    output logic       busy,
    output logic       adr_par_err,
    output logic       nxm_err
);

    localparam int AW = $clog2(MEMSIZE);

    mseq_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          port_b_q, port_b_d;
    logic          op_wr_q, op_wr_d;
    logic [1:0]    first_q, first_d;
    logic [3:0]    pend_q, pend_d;
    logic [AW-3:0] qbase_q, qbase_d;
    logic          ackn_a_q, ackn_a_d;
    logic          ackn_b_q, ackn_b_d;
    logic          par_err_q, par_err_d;
    logic          nxm_err_q, nxm_err_d;

    logic [1:0]    cur_slot;
    logic [3:0]    pend_next;
    logic          req_ok;
    logic          par_bad;
    logic          nxm;
    logic [31:0]   qw_base;
    logic          ov_sel;
    logic          rd_valid;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    word_t         ram_rdata;

    // The RAM always reads the current slot, so the word is ready one cycle before it is shown.
    assign cur_slot  = next_slot(pend_q, first_q);
    assign pend_next = pend_q & ~(4'b0001 << cur_slot);
    assign ram_addr  = {qbase_q, cur_slot};

    assign req_ok  = (start_a | start_b) & (rd_rq ^ wr_rq) & (rq != 4'b0000);
    assign par_bad = (odd_par({14'b0, adr}) != adr_par);
    assign qw_base = {8'b0, adr[21:2], 2'b00};
    assign nxm     = (qw_base >= 32'(MEMSIZE));
    assign ov_sel  = port_b_q ? out_valid_b : out_valid_a;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            port_b_q  <= 1'b0;
            op_wr_q   <= 1'b0;
            first_q   <= 2'd0;
            pend_q    <= 4'd0;
            qbase_q   <= '0;
            ackn_a_q  <= 1'b0;
            ackn_b_q  <= 1'b0;
            par_err_q <= 1'b0;
            nxm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_b_q  <= port_b_d;
            op_wr_q   <= op_wr_d;
            first_q   <= first_d;
            pend_q    <= pend_d;
            qbase_q   <= qbase_d;
            ackn_a_q  <= ackn_a_d;
            ackn_b_q  <= ackn_b_d;
            par_err_q <= par_err_d;
            nxm_err_q <= nxm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_b_d  = port_b_q;
        op_wr_d   = op_wr_q;
        first_d   = first_q;
        pend_d    = pend_q;
        qbase_d   = qbase_q;
        ackn_a_d  = 1'b0;
        ackn_b_d  = 1'b0;
        par_err_d = par_err_q;
        nxm_err_d = nxm_err_q;
        ram_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    if (par_bad) begin
                        par_err_d = 1'b1;
                    end
                    if (nxm) begin
                        nxm_err_d = 1'b1;
                    end
                    if (!par_bad && !nxm) begin
                        state_d  = ST_ACK;
                        cnt_d    = 4'(ACK_DLY - 1);
                        port_b_d = ~start_a;
                        op_wr_d  = wr_rq;
                        first_d  = adr[1:0];
                        pend_d   = rq;
                        qbase_d  = adr[AW-1:2];
                    end
                end
            end
            ST_ACK: begin
                if (cnt_q == 4'd0) begin
                    ackn_a_d = ~port_b_q;
                    ackn_b_d = port_b_q;
                    state_d  = op_wr_q ? ST_WRXFER : ST_ACCESS;
                    cnt_d    = 4'(ACCESS_DLY - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                // Last wait cycle doubles as the prefetch of the first word.
                if (cnt_q == 4'd0) begin
                    pend_d  = pend_next;
                    state_d = ST_RDXFER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RDXFER: begin
                if (pend_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    pend_d = pend_next;
                end
            end
            ST_WRXFER: begin
                if (ov_sel) begin
                    ram_we = 1'b1;
                    pend_d = pend_next;
                    if (pend_next == 4'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mem_reset) begin
            state_d   = ST_IDLE;
            ackn_a_d  = 1'b0;
            ackn_b_d  = 1'b0;
            par_err_d = 1'b0;
            nxm_err_d = 1'b0;
            ram_we    = 1'b0;
        end
    end

    mem_ram #(
        .DEPTH (MEMSIZE),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (d_out),
        .rdata_o (ram_rdata)
    );

    assign rd_valid    = (state_q == ST_RDXFER);
    assign in_valid_a  = rd_valid & ~port_b_q;
    assign in_valid_b  = rd_valid & port_b_q;
    assign d_in        = rd_valid ? ram_rdata : '0;
    assign par_in      = rd_valid ? odd_par(ram_rdata) : 1'b1;
    assign busy        = (state_q != ST_IDLE);
    assign ackn_a      = ackn_a_q;
    assign ackn_b      = ackn_b_q;
    assign adr_par_err = par_err_q;
    assign nxm_err     = nxm_err_q;

endmodule

// File: tb/tb_mbus_mem_seq.sv
// Self-checking bench for mbus_mem_seq: request acceptance table plus directed read/write sequences.
module tb_mbus_mem_seq;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        start_a, start_b, rd_rq, wr_rq;
    logic [3:0]  rq;
    logic [21:0] adr;
    logic        adr_par, mem_reset;
    logic [35:0] d_out;
    logic        out_valid_a, out_valid_b;
    logic        ackn_a, ackn_b;
    logic [35:0] d_in;
    logic        par_in, in_valid_a, in_valid_b, busy, adr_par_err, nxm_err;

    int checks   = 0;
    int failures = 0;
    int ackACount = 0;
    int ackBCount = 0;

    logic [35:0] model [int];

    typedef struct {
        string       name;
        logic        sa, sb, rd, wr;
        logic [3:0]  m;
        logic [21:0] a;
        logic        badPar;
        int          expAckA, expAckB;
        int          expPar, expNxm;
    } vec_t;

    vec_t vecs [11];

    mbus_mem_seq dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .start_a     (start_a),
        .start_b     (start_b),
        .rd_rq       (rd_rq),
        .wr_rq       (wr_rq),
        .rq          (rq),
        .adr         (adr),
        .adr_par     (adr_par),
        .mem_reset   (mem_reset),
        .d_out       (d_out),
        .out_valid_a (out_valid_a),
        .out_valid_b (out_valid_b),
        .ackn_a      (ackn_a),
        .ackn_b      (ackn_b),
        .d_in        (d_in),
        .par_in      (par_in),
        .in_valid_a  (in_valid_a),
        .in_valid_b  (in_valid_b),
        .busy        (busy),
        .adr_par_err (adr_par_err),
        .nxm_err     (nxm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ackn_a === 1'b1) ackACount++;
        if (ackn_b === 1'b1) ackBCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One-cycle request: driven at a falling edge, accepted on the next rising edge,
    // released at the following falling edge (call that point cycle 0).
    task automatic applyStimulus(input logic sa, input logic sb, input logic rd, input logic wr,
                                 input logic [3:0] m, input logic [21:0] a, input logic badPar);
        @(negedge clk);
        start_a = sa;
        start_b = sb;
        rd_rq   = rd;
        wr_rq   = wr;
        rq      = m;
        adr     = a;
        adr_par = (~^a) ^ badPar;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        rd_rq   = 1'b0;
        wr_rq   = 1'b0;
        rq      = 4'b0000;
    endtask

    task automatic orderOf(input logic [1:0] f, input logic [3:0] m, output int sl[4], output int n);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (int'(f) + k) % 4;
            sl[k] = 0;
            if (m[s]) begin
                sl[n] = s;
                n++;
            end
        end
    endtask

    task automatic driveOv(input bit portB, input logic mine, input logic other);
        if (portB) begin
            out_valid_b = mine;
            out_valid_a = other;
        end else begin
            out_valid_a = mine;
            out_valid_b = other;
        end
    endtask

    task automatic doWrite(input bit portB, input logic [21:0] a, input logic [3:0] m,
                           input logic [35:0] seed, input int gap1, input int stopAfter);
        int sl[4];
        int n, ackAt, words, base, a0, b0;
        orderOf(a[1:0], m, sl, n);
        base = int'({a[21:2], 2'b00});
        a0 = ackACount;
        b0 = ackBCount;
        applyStimulus(~portB, portB, 1'b0, 1'b1, m, a, 1'b0);
        ackAt = -1;
        for (int i = 0; i < 10 && ackAt < 0; i++) begin
            if ((portB ? ackn_b : ackn_a) === 1'b1) ackAt = i;
            else @(negedge clk);
        end
        checkInt("wr_ack_latency", ackAt, 2);
        if (ackAt < 0) return;
        words = 0;
        for (int k = 0; k < n && words < stopAfter; k++) begin
            int gap;
            gap = (words == 1) ? gap1 : 0;
            repeat (gap) begin
                d_out = 36'hBADBADBAD;
                driveOv(portB, 1'b0, 1'b1);
                @(negedge clk);
                driveOv(portB, 1'b0, 1'b0);
            end
            d_out = seed + 36'(sl[k]);
            model[base + sl[k]] = seed + 36'(sl[k]);
            driveOv(portB, 1'b1, 1'b0);
            @(negedge clk);
            driveOv(portB, 1'b0, 1'b0);
            words++;
        end
        if (words < n) begin
            mem_reset = 1'b1;
            @(negedge clk);
            mem_reset = 1'b0;
        end
        checkInt("wr_busy_drop", int'(busy), 0);
        checkInt("wr_ack_mine", portB ? ackBCount - b0 : ackACount - a0, 1);
        checkInt("wr_ack_other", portB ? ackACount - a0 : ackBCount - b0, 0);
    endtask

    task automatic doRead(input bit portB, input logic [21:0] a, input logic [3:0] m, input int intrudeAt);
        int sl[4];
        int n, base, a0, b0;
        int ackAt, firstV, lastV, vCount, seqErr, idleErr, wrongVal, busyAfter;
        orderOf(a[1:0], m, sl, n);
        base = int'({a[21:2], 2'b00});
        a0 = ackACount;
        b0 = ackBCount;
        ackAt = -1; firstV = -1; lastV = -1; vCount = 0;
        seqErr = 0; idleErr = 0; wrongVal = 0; busyAfter = -1;
        applyStimulus(~portB, portB, 1'b1, 1'b0, m, a, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i == intrudeAt) begin
                start_b = 1'b1;
                rd_rq   = 1'b1;
                rq      = 4'b0001;
                adr     = 22'o0;
                adr_par = 1'b1;
            end else if (i == intrudeAt + 1) begin
                start_b = 1'b0;
                rd_rq   = 1'b0;
                rq      = 4'b0000;
            end
            if (lastV >= 0 && i == lastV + 1) busyAfter = int'(busy);
            if (ackAt < 0 && (portB ? ackn_b : ackn_a) === 1'b1) ackAt = i;
            if ((portB ? in_valid_b : in_valid_a) === 1'b1) begin
                if (firstV < 0) firstV = i;
                if (i != firstV + vCount) seqErr++;
                if (vCount < n) begin
                    checkOutput($sformatf("rd_word_%0d", base + sl[vCount]), d_in, model[base + sl[vCount]]);
                    checkInt("rd_par", int'(par_in), int'(~^model[base + sl[vCount]]));
                end
                vCount++;
                lastV = i;
            end else if (d_in !== 36'd0 || par_in !== 1'b1) begin
                idleErr++;
            end
            if ((portB ? in_valid_a : in_valid_b) === 1'b1) wrongVal++;
            @(negedge clk);
        end
        checkInt("rd_ack_latency", ackAt, 2);
        checkInt("rd_first_valid", firstV, 6);
        checkInt("rd_word_count", vCount, n);
        checkInt("rd_consecutive_err", seqErr, 0);
        checkInt("rd_idle_data_err", idleErr, 0);
        checkInt("rd_other_valid", wrongVal, 0);
        checkInt("rd_busy_after_last", busyAfter, 0);
        checkInt("rd_ack_mine", portB ? ackBCount - b0 : ackACount - a0, 1);
        checkInt("rd_ack_other", portB ? ackACount - a0 : ackBCount - b0, 0);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{"rej_rq0",    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 22'o1000,   1'b0, 0, 0, 0, 0};
        vecs[1]  = '{"rej_rd_wr",  1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 22'o1000,   1'b0, 0, 0, 0, 0};
        vecs[2]  = '{"rej_none",   1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 22'o1000,   1'b0, 0, 0, 0, 0};
        vecs[3]  = '{"acc_a_rd",   1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 22'o1000,   1'b0, 1, 0, 0, 0};
        vecs[4]  = '{"acc_b_wr",   1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 22'o2000,   1'b0, 0, 1, 0, 0};
        vecs[5]  = '{"both_start", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 22'o1000,   1'b0, 1, 0, 0, 0};
        vecs[6]  = '{"bad_par",    1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 22'o1000,   1'b1, 0, 0, 1, 0};
        vecs[7]  = '{"nxm_base",   1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 22'd262144, 1'b0, 0, 0, 0, 1};
        vecs[8]  = '{"nxm_top",    1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 22'h3FFFFF, 1'b0, 0, 0, 0, 1};
        vecs[9]  = '{"last_qw_ok", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 22'd262143, 1'b0, 1, 0, 0, 0};
        vecs[10] = '{"no_start",   1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 22'o0,      1'b0, 0, 0, 0, 0};

        reset_l = 1'b0;
        start_a = 1'b0; start_b = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0;
        rq = 4'b0000; adr = 22'o0; adr_par = 1'b1; mem_reset = 1'b0;
        d_out = 36'd0; out_valid_a = 1'b0; out_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        checkInt("rst_ackn_a", int'(ackn_a), 0);
        checkInt("rst_ackn_b", int'(ackn_b), 0);
        checkInt("rst_in_valid", int'(in_valid_a | in_valid_b), 0);
        checkOutput("rst_d_in", d_in, 36'd0);
        checkInt("rst_par_in", int'(par_in), 1);
        checkInt("rst_busy", int'(busy), 0);
        checkInt("rst_errs", int'(adr_par_err | nxm_err), 0);
        reset_l = 1'b1;

        foreach (vecs[v]) begin
            int a0, b0, busy0;
            a0 = ackACount;
            b0 = ackBCount;
            applyStimulus(vecs[v].sa, vecs[v].sb, vecs[v].rd, vecs[v].wr, vecs[v].m, vecs[v].a, vecs[v].badPar);
            busy0 = int'(busy);
            repeat (5) @(negedge clk);
            checkInt({vecs[v].name, "_ackA"}, ackACount - a0, vecs[v].expAckA);
            checkInt({vecs[v].name, "_ackB"}, ackBCount - b0, vecs[v].expAckB);
            checkInt({vecs[v].name, "_busy"}, busy0, vecs[v].expAckA + vecs[v].expAckB);
            checkInt({vecs[v].name, "_parerr"}, int'(adr_par_err), vecs[v].expPar);
            checkInt({vecs[v].name, "_nxm"}, int'(nxm_err), vecs[v].expNxm);
            mem_reset = 1'b1;
            @(negedge clk);
            mem_reset = 1'b0;
            checkInt({vecs[v].name, "_clr_errs"}, int'(adr_par_err | nxm_err), 0);
            checkInt({vecs[v].name, "_clr_busy"}, int'(busy), 0);
        end

        $display("[TB] preload and quadword read");
        doWrite(1'b0, 22'o1000, 4'b1111, 36'h111110000, 0, 4);
        doRead(1'b0, 22'o1002, 4'b1111, -1);

        $display("[TB] port B sparse write with gaps");
        doWrite(1'b1, 22'o2000, 4'b1111, 36'h222220000, 0, 4);
        doWrite(1'b1, 22'o2003, 4'b0101, 36'h333330000, 5, 4);
        doRead(1'b1, 22'o2000, 4'b1111, -1);

        $display("[TB] start_b while busy, wrap order");
        doRead(1'b0, 22'o1001, 4'b0010, 3);
        doRead(1'b0, 22'o1003, 4'b1001, -1);

        $display("[TB] mem_reset mid-write");
        doWrite(1'b0, 22'o1000, 4'b1111, 36'h444440000, 0, 2);
        doRead(1'b0, 22'o1000, 4'b1111, -1);

        $display("[TB] reset_l mid-read");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 22'o1000, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            if (in_valid_a === 1'b1) seen++;
            if (seen < 2) @(negedge clk);
        end
        checkInt("rstmid_two_words", seen, 2);
        #2 reset_l = 1'b0;
        #1;
        checkInt("rstmid_in_valid", int'(in_valid_a | in_valid_b), 0);
        checkOutput("rstmid_d_in", d_in, 36'd0);
        checkInt("rstmid_par_in", int'(par_in), 1);
        checkInt("rstmid_busy", int'(busy), 0);
        checkInt("rstmid_ackn", int'(ackn_a | ackn_b), 0);
        @(negedge clk);
        reset_l = 1'b1;
        doWrite(1'b0, 22'o1000, 4'b1111, 36'h555550000, 0, 4);
        doRead(1'b0, 22'o1001, 4'b1111, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
